// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: reassembles LSB-first bit streams into
// WIDTH-bit words, frame-aligned by a sync marker, with a 2-entry output FIFO.
module serial_deser #(
  parameter int WIDTH    = 4,
  parameter bit REQ_SYNC = 1'b1,
  localparam int CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  output logic             align_err,
  input  logic             clr_err
);

  typedef enum logic {HUNT, ASSEMBLE} state_t;

  localparam state_t     RESET_STATE = REQ_SYNC ? HUNT : ASSEMBLE;
  localparam [CW-1:0]    LAST_BIT    = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-2:0]   asm_q, asm_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]         count_q, count_d;
  logic               overrun_q, overrun_d, align_q, align_d;

  logic [WIDTH-1:0]   word;
  logic               push, pop, over_set, align_set;

  // The assembly register keeps only the upper WIDTH-1 bits; the incoming bit
  // always completes the word at the MSB.
  assign word = {sin, asm_q};
  assign pop  = (count_q != 2'd0) && dout_ready;

  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    align_set = 1'b0;
    if (sin_valid) begin
      if (state_q == HUNT) begin
        if (sync) begin
          state_d            = ASSEMBLE;
          asm_d              = '0;
          asm_d[WIDTH-2]     = sin;
          cnt_d              = CW'(1);
        end
      end else if (sync && (cnt_q != '0)) begin
        align_set          = 1'b1;
        asm_d              = '0;
        asm_d[WIDTH-2]     = sin;
        cnt_d              = CW'(1);
      end else begin
        asm_d = word[WIDTH-1:1];
        if (cnt_q == LAST_BIT) begin
          push  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Head entry is a register so dout stays stable under backpressure.
  always_comb begin
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    count_d  = count_q;
    over_set = 1'b0;
    if (push) begin
      case (count_q)
        2'd0: begin
          buf0_d  = word;
          count_d = 2'd1;
        end
        2'd1: begin
          if (pop) begin
            buf0_d = word;
          end else begin
            buf1_d  = word;
            count_d = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            buf0_d = buf1_q;
            buf1_d = word;
          end else begin
            over_set = 1'b1;
          end
        end
      endcase
    end else if (pop) begin
      if (count_q == 2'd2) buf0_d = buf1_q;
      count_d = count_q - 2'd1;
    end
  end

  assign overrun_d = over_set  | (overrun_q & ~clr_err);
  assign align_d   = align_set | (align_q   & ~clr_err);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= RESET_STATE;
      asm_q     <= '0;
      cnt_q     <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      count_q   <= 2'd0;
      overrun_q <= 1'b0;
      align_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      align_q   <= align_d;
    end
  end

  assign dout       = buf0_q;
  assign dout_valid = (count_q != 2'd0);
  assign bit_cnt    = cnt_q;
  assign overrun    = overrun_q;
  assign align_err  = align_q;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based word model.
module tb_serial_deser;

  localparam int W = 4;

  logic         Clock;
  logic         Resetn;
  logic         sin, sin_valid, sync, dout_ready, clr_err;
  logic [W-1:0] dout;
  logic         dout_valid, overrun, align_err;
  logic [1:0]   bit_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: hunting flag, number of bits collected, word value so far,
  // FIFO contents and sticky flags.
  bit hunting;
  int nbits;
  int acc;
  int q[$];
  bit ovE, alE;

  serial_deser #(.WIDTH(W), .REQ_SYNC(1'b1)) dut (
    .Clock(Clock), .Resetn(Resetn), .sin(sin), .sin_valid(sin_valid),
    .sync(sync), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .bit_cnt(bit_cnt), .overrun(overrun),
    .align_err(align_err), .clr_err(clr_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic sy,
                               input logic rdy, input logic clr);
    sin        = s;
    sin_valid  = v;
    sync       = sy;
    dout_ready = rdy;
    clr_err    = clr;
    @(posedge Clock);
    #1;
  endtask

  task automatic sendWord(input int value, input bit withSync, input logic rdy);
    for (int i = 0; i < W; i++)
      applyStimulus(logic'((value >> i) & 1), 1'b1, (i == 0) && withSync, rdy, 1'b0);
  endtask

  task automatic doReset();
    Resetn = 1'b0;
    sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  // Reference model: words built from LSB-first bits, FIFO of at most two.
  always @(posedge Clock or negedge Resetn) begin : model
    bit popE, ovSet, alSet;
    int pushW;
    if (!Resetn) begin
      hunting = 1'b1; nbits = 0; acc = 0; q.delete(); ovE = 1'b0; alE = 1'b0;
    end else begin
      popE  = (q.size() > 0) && dout_ready;
      pushW = -1;
      ovSet = 1'b0;
      alSet = 1'b0;
      if (sin_valid) begin
        if (hunting) begin
          if (sync) begin hunting = 1'b0; acc = int'(sin); nbits = 1; end
        end else if (sync && nbits != 0) begin
          alSet = 1'b1; acc = int'(sin); nbits = 1;
        end else begin
          acc = acc + (int'(sin) << nbits);
          nbits++;
          if (nbits == W) begin pushW = acc; acc = 0; nbits = 0; end
        end
      end
      if (popE) void'(q.pop_front());
      if (pushW >= 0) begin
        if (q.size() < 2) q.push_back(pushW);
        else ovSet = 1'b1;
      end
      ovE = ovSet | (ovE & !clr_err);
      alE = alSet | (alE & !clr_err);
    end
  end

  bit cmpEn = 1'b0;

  always @(negedge Clock) begin
    if (cmpEn) begin
      checkOutput("dout_valid", int'(dout_valid), (q.size() > 0) ? 1 : 0);
      checkOutput("bit_cnt", int'(bit_cnt), nbits);
      checkOutput("overrun", int'(overrun), int'(ovE));
      checkOutput("align_err", int'(align_err), int'(alE));
      if (q.size() > 0) checkOutput("dout", int'(dout), q[0]);
    end
  end

  initial begin
    int bitsD[4];
    bitsD = '{1, 0, 1, 1};
    doReset();

    checkOutput("rst_dout", int'(dout), 0);
    checkOutput("rst_valid", int'(dout_valid), 0);
    checkOutput("rst_bitcnt", int'(bit_cnt), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_align", int'(align_err), 0);
    cmpEn = 1'b1;

    $display("[TB] decode");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(logic'(bitsD[i]), 1'b1, i == 0, 1'b1, 1'b0);
      checkOutput("dec_bitcnt", int'(bit_cnt), (i + 1) % 4);
    end
    checkOutput("dec_valid", int'(dout_valid), 1);
    checkOutput("dec_dout", int'(dout), 13);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("dec_pulse", int'(dout_valid), 0);

    $display("[TB] hunt");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("hunt_bitcnt", int'(bit_cnt), 0);
    sendWord(2, 1'b1, 1'b1);
    checkOutput("hunt_dout", int'(dout), 2);
    checkOutput("hunt_valid", int'(dout_valid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hunt_single", int'(dout_valid), 0);

    $display("[TB] gaps");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(logic'(bitsD[i]), 1'b1, i == 0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i < 3) checkOutput("gap_hold", int'(bit_cnt), i + 1);
    end
    checkOutput("gap_dout_gone", int'(dout_valid), 0);

    $display("[TB] backpressure");
    doReset();
    sendWord(1, 1'b1, 1'b0);
    sendWord(2, 1'b0, 1'b0);
    sendWord(3, 1'b0, 1'b0);
    checkOutput("bp_overrun", int'(overrun), 1);
    checkOutput("bp_head", int'(dout), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_second", int'(dout), 2);
    checkOutput("bp_second_v", int'(dout_valid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_empty", int'(dout_valid), 0);

    $display("[TB] misalignment");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("mis_bitcnt", int'(bit_cnt), 2);
    sendWord(14, 1'b1, 1'b0);
    checkOutput("mis_align", int'(align_err), 1);
    checkOutput("mis_dout", int'(dout), 14);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mis_only", int'(dout_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mis_clr", int'(align_err), 0);

    $display("[TB] reset mid-word");
    doReset();
    sendWord(13, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rw_bitcnt", int'(bit_cnt), 2);
    checkOutput("rw_valid", int'(dout_valid), 1);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("rw_async_valid", int'(dout_valid), 0);
    checkOutput("rw_async_dout", int'(dout), 0);
    checkOutput("rw_async_cnt", int'(bit_cnt), 0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rw_hunting", int'(bit_cnt), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rw_synced", int'(bit_cnt), 1);

    $display("[TB] random");
    doReset();
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(logic'($urandom_range(1)),
                    $urandom_range(99) < 70,
                    $urandom_range(99) < 12,
                    $urandom_range(99) < 55,
                    $urandom_range(99) < 4);
    end

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
